vga_text80: RTL

- Upstream pixel source for the board's VGA output. Runs 640x480@60 timing from the 25 MHz pixel clock.
- Renders an 80x25 text screen with 8x16 glyphs. Reads character/attribute words from a synchronous video RAM and glyph rows from a synchronous font ROM.
- Drives 4-bit R/G/B plus HS/VS straight to the connector pins.
- Also provides a blinking underline cursor.

---
 rtl/vga_text80.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vga_text80.sv
// 640x480@60 text-mode pixel source: 80x25 cells of 8x16 glyphs fetched from an
// external video RAM and font ROM, with a blinking underline cursor.
module vga_text80 #(
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int V_TOP        = 40,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic [10:0] VRAM_A,
  input  logic [15:0] VRAM_Q,
  output logic [11:0] FONT_A,
  input  logic [7:0]  FONT_Q,
  input  logic [6:0]  CURSOR_X,
  input  logic [4:0]  CURSOR_Y,
  input  logic        CURSOR_EN,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        FRAME
);
  localparam int H_TOT      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int TEXT_LINES = V_VIS - 2 * V_TOP;
  localparam int BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [9:0]    x, y;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          frame_end;

  assign frame_end = (x == 10'(H_TOT - 1)) && (y == 10'(V_TOT - 1));

  // The blink counter advances once per completed frame, so a fresh reset
  // shows BLINK_FRAMES full frames before the first cursor phase change.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      x           <= '0;
      y           <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (x == 10'(H_TOT - 1)) begin
        x <= '0;
        y <= (y == 10'(V_TOT - 1)) ? '0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
      if (frame_end) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  logic [8:0] ty;
  logic [4:0] row;
  logic [6:0] col;
  logic       active0, hit0, hs0, vs0, frame0;

  assign ty      = y[8:0] - 9'(V_TOP);
  assign row     = ty[8:4];
  assign col     = x[9:3];
  assign active0 = (x < 10'(H_VIS)) && (y >= 10'(V_TOP)) && (y < 10'(V_TOP + TEXT_LINES));
  assign hit0    = (col == CURSOR_X) && (row == CURSOR_Y) && (CURSOR_X < 7'd80) && (CURSOR_Y < 5'd25);
  assign hs0     = !((x >= 10'(H_VIS + H_FP)) && (x < 10'(H_VIS + H_FP + H_SYNC)));
  assign vs0     = !((y >= 10'(V_VIS + V_FP)) && (y < 10'(V_VIS + V_FP + V_SYNC)));
  assign frame0  = (x == '0) && (y == '0);
  assign VRAM_A  = active0 ? (11'(row) * 11'd80 + 11'(col)) : 11'd0;

  logic [2:0] xbit1, xbit2;
  logic [3:0] line1, line2, fg2, bg2;
  logic       active1, hit1, hs1, vs1, frame1;
  logic       active2, hit2, hs2, vs2, frame2;

  assign FONT_A = active1 ? {VRAM_Q[7:0], line1} : 12'd0;

  // Two pipeline stages cover the RAM and ROM read latencies; syncs idle high.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      xbit1 <= '0; line1 <= '0; active1 <= 1'b0; hit1 <= 1'b0;
      hs1 <= 1'b1; vs1 <= 1'b1; frame1 <= 1'b0;
      xbit2 <= '0; line2 <= '0; active2 <= 1'b0; hit2 <= 1'b0;
      hs2 <= 1'b1; vs2 <= 1'b1; frame2 <= 1'b0; fg2 <= '0; bg2 <= '0;
    end else begin
      xbit1 <= x[2:0]; line1 <= ty[3:0]; active1 <= active0; hit1 <= hit0;
      hs1 <= hs0; vs1 <= vs0; frame1 <= frame0;
      xbit2 <= xbit1; line2 <= line1; active2 <= active1; hit2 <= hit1;
      hs2 <= hs1; vs2 <= vs1; frame2 <= frame1;
      fg2 <= VRAM_Q[11:8];
      bg2 <= VRAM_Q[15:12];
    end
  end

  logic       pix2, cursor_on2;
  logic [3:0] colour2;

  assign pix2       = FONT_Q[3'd7 - xbit2];
  assign cursor_on2 = hit2 && blink_phase && CURSOR_EN && (line2[3:1] == 3'b111);
  assign colour2    = (pix2 || cursor_on2) ? fg2 : bg2;

  function automatic logic [3:0] level(input logic intensity, input logic on);
    if (on) return intensity ? 4'hF : 4'hA;
    return intensity ? 4'h5 : 4'h0;
  endfunction

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      VGA_R <= '0; VGA_G <= '0; VGA_B <= '0;
      VGA_HS <= 1'b1; VGA_VS <= 1'b1; FRAME <= 1'b0;
    end else begin
      VGA_R  <= active2 ? level(colour2[3], colour2[2]) : 4'h0;
      VGA_G  <= active2 ? level(colour2[3], colour2[1]) : 4'h0;
      VGA_B  <= active2 ? level(colour2[3], colour2[0]) : 4'h0;
      VGA_HS <= hs2;
      VGA_VS <= vs2;
      FRAME  <= frame2;
    end
  end
endmodule
